// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives PC to instruction memory and holds the
// fetched word for decode, with redirect, stall and misaligned-target trap.
module fetch_unit #(
  parameter int unsigned PC_WIDTH_LENGTH   = 32,
  parameter int unsigned INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [PC_WIDTH_LENGTH-1:0]   PC,
  input  logic [INST_WIDTH_LENGTH-1:0] inst,
  input  logic                         redirect,
  input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
  input  logic                         id_ready,
  output logic                         id_valid,
  output logic [INST_WIDTH_LENGTH-1:0] id_inst,
  output logic [PC_WIDTH_LENGTH-1:0]   id_pc,
  output logic [PC_WIDTH_LENGTH-1:0]   id_pc4,
  output logic                         misalign,
  output logic [31:0]                  fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TRAP
  } state_t;

  localparam logic [PC_WIDTH_LENGTH-1:0] STEP = PC_WIDTH_LENGTH'(4);

  state_t state;
  logic   xfer;
  logic   cap;
  logic   bad_tgt;
  logic [PC_WIDTH_LENGTH-1:0] pc_next;

  assign xfer    = id_valid & id_ready;
  assign bad_tgt = |redirect_pc[1:0];
  assign pc_next = PC + STEP;
  // inst is only looked at on a capture cycle
  assign cap     = (state == RUN) & ~redirect & (~id_valid | id_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      PC        <= RESET_PC;
      id_valid  <= 1'b0;
      id_inst   <= '0;
      id_pc     <= '0;
      id_pc4    <= '0;
      misalign  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      if (xfer) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      unique case (state)
        IDLE: begin
          state    <= RUN;
          misalign <= 1'b0;
        end
        RUN, TRAP: begin
          if (redirect) begin
            id_valid <= 1'b0;
            PC       <= redirect_pc;
            state    <= bad_tgt ? TRAP : RUN;
            misalign <= bad_tgt;
          end else if (cap) begin
            id_inst  <= inst;
            id_pc    <= PC;
            id_pc4   <= pc_next;
            id_valid <= 1'b1;
            PC       <= pc_next;
          end else if (state == RUN && xfer) begin
            id_valid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          misalign <= 1'b0;
        end
      endcase
    end
  end

endmodule
